// File: rtl/me1_stage_reg_t_if.sv
// me1_stage_reg_t_if
// EX1 -> ME1 transfer bundle plus handshake.
//   master : EX1/ME1 side (drives ACT, *_D, me_ready, flush; observes in_ready, *_Q)
//   slave  : the stage register (me1_stage_reg_t)
// Signals:
//   ACT, r_me1_*_D          offered beat from EX1
//   in_ready                buffer can take a beat (registered)
//   me_ready                ME1 consumes the head entry this cycle
//   flush                   discard held and incoming beats
//   r_me1_valid_Q, r_me1_*_Q head entry presented to ME1
interface me1_stage_reg_t_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            ACT;
  logic            r_me1_valid_D;
  logic [XLEN-1:0] r_me1_pc_D;
  logic [XLEN-1:0] r_me1_alu_D;
  logic [XLEN-1:0] r_me1_bradd_D;
  logic [XLEN-1:0] r_me1_wtdat_D;
  logic [RD_W-1:0] r_me1_rd_D;
  logic            r_me1_regwrite_D;
  logic [1:0]      r_me1_rfwt_sel_D;
  logic [3:0]      r_me1_memop_D;
  logic [2:0]      r_me1_branchop_D;
  logic            r_me1_zero_D;
  logic            r_me1_order_D;

  logic            in_ready;
  logic            me_ready;
  logic            flush;

  logic            r_me1_valid_Q;
  logic [XLEN-1:0] r_me1_pc_Q;
  logic [XLEN-1:0] r_me1_alu_Q;
  logic [XLEN-1:0] r_me1_bradd_Q;
  logic [XLEN-1:0] r_me1_wtdat_Q;
  logic [RD_W-1:0] r_me1_rd_Q;
  logic            r_me1_regwrite_Q;
  logic [1:0]      r_me1_rfwt_sel_Q;
  logic [3:0]      r_me1_memop_Q;
  logic [2:0]      r_me1_branchop_Q;
  logic            r_me1_zero_Q;
  logic            r_me1_order_Q;

  modport master (
    output ACT, r_me1_valid_D, r_me1_pc_D, r_me1_alu_D, r_me1_bradd_D,
           r_me1_wtdat_D, r_me1_rd_D, r_me1_regwrite_D, r_me1_rfwt_sel_D,
           r_me1_memop_D, r_me1_branchop_D, r_me1_zero_D, r_me1_order_D,
           me_ready, flush,
    input  in_ready, r_me1_valid_Q, r_me1_pc_Q, r_me1_alu_Q, r_me1_bradd_Q,
           r_me1_wtdat_Q, r_me1_rd_Q, r_me1_regwrite_Q, r_me1_rfwt_sel_Q,
           r_me1_memop_Q, r_me1_branchop_Q, r_me1_zero_Q, r_me1_order_Q
  );

  modport slave (
    input  ACT, r_me1_valid_D, r_me1_pc_D, r_me1_alu_D, r_me1_bradd_D,
           r_me1_wtdat_D, r_me1_rd_D, r_me1_regwrite_D, r_me1_rfwt_sel_D,
           r_me1_memop_D, r_me1_branchop_D, r_me1_zero_D, r_me1_order_D,
           me_ready, flush,
    output in_ready, r_me1_valid_Q, r_me1_pc_Q, r_me1_alu_Q, r_me1_bradd_Q,
           r_me1_wtdat_Q, r_me1_rd_Q, r_me1_regwrite_Q, r_me1_rfwt_sel_Q,
           r_me1_memop_Q, r_me1_branchop_Q, r_me1_zero_Q, r_me1_order_Q
  );
endinterface

// File: rtl/me1_stage_reg_t.sv
// me1_stage_reg_t
// Receiving end of the EX1->ME1 transfer. Beats written by EX1 (ACT with
// r_me1_valid_D) are held in a 2-entry in-order skid buffer (MAIN + SKID);
// MAIN drives the registered r_me1_*_Q outputs toward ME1.
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous reset, active high (clears state and all Q outputs)
//   bus      me1_stage_reg_t_if.slave: ACT/*_D in, in_ready out, me_ready and
//            flush in, r_me1_valid_Q/*_Q out
//   br_taken, br_target  only when ME1_BRANCH_RESOLVE_EN is defined: branch
//            outcome/target resolved combinationally from MAIN, gated by
//            r_me1_valid_Q
// Optional build macro: ME1_BRANCH_RESOLVE_EN
module me1_stage_reg_t #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  me1_stage_reg_t_if.slave bus
`ifdef ME1_BRANCH_RESOLVE_EN
  ,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target
`endif
);

  // Payload: pc, alu, bradd, wtdat, rd, regwrite, rfwt_sel(2), memop(4),
  // branchop(3), zero, order. valid is not stored: it follows occupancy.
  localparam int PW = 4*XLEN + RD_W + 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          in_ready_r;
  logic          accept, pop;
  logic          load_main_beat, load_main_skid, load_skid_beat;
  logic [PW-1:0] beat_p0;
  logic [PW-1:0] main_p1;
  logic [PW-1:0] skid_p1;

  // ---- stage p0: incoming beat from EX1 ----
  assign beat_p0 = {bus.r_me1_pc_D, bus.r_me1_alu_D, bus.r_me1_bradd_D,
                    bus.r_me1_wtdat_D, bus.r_me1_rd_D, bus.r_me1_regwrite_D,
                    bus.r_me1_rfwt_sel_D, bus.r_me1_memop_D,
                    bus.r_me1_branchop_D, bus.r_me1_zero_D, bus.r_me1_order_D};

  // Bubbles are never stored; flush drops a same-cycle accept.
  assign accept = bus.ACT & bus.r_me1_valid_D & in_ready_r & ~bus.flush;
  assign pop    = (state != EMPTY) & bus.me_ready;

  always_comb begin
    state_nxt      = state;
    load_main_beat = 1'b0;
    load_main_skid = 1'b0;
    load_skid_beat = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_beat = 1'b1;
            state_nxt      = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_beat = 1'b1;
          end else if (accept) begin
            load_skid_beat = 1'b1;
            state_nxt      = FULL;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---- stage p1: MAIN/SKID storage ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= EMPTY;
      in_ready_r <= 1'b1;
      main_p1    <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_r <= (state_nxt != FULL);
      if (load_main_beat) begin
        main_p1 <= beat_p0;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
    end
  end

  // SKID content is only ever read in FULL, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (load_skid_beat) begin
      skid_p1 <= beat_p0;
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.r_me1_valid_Q = (state != EMPTY);
  assign {bus.r_me1_pc_Q, bus.r_me1_alu_Q, bus.r_me1_bradd_Q,
          bus.r_me1_wtdat_Q, bus.r_me1_rd_Q, bus.r_me1_regwrite_Q,
          bus.r_me1_rfwt_sel_Q, bus.r_me1_memop_Q, bus.r_me1_branchop_Q,
          bus.r_me1_zero_Q, bus.r_me1_order_Q} = main_p1;

`ifdef ME1_BRANCH_RESOLVE_EN
  function automatic logic resolve_branch(input logic [2:0] op,
                                          input logic       zero);
    case (op)
      3'b000:  return 1'b0;
      3'b001:  return zero;
      3'b010:  return ~zero;
      3'b011:  return 1'b1;
      default: return zero;
    endcase
  endfunction

  assign br_taken  = bus.r_me1_valid_Q &
                     resolve_branch(bus.r_me1_branchop_Q, bus.r_me1_zero_Q);
  assign br_target = bus.r_me1_bradd_Q;
`endif

endmodule

// File: tb/tb_me1_stage_reg_t.sv
module tb_me1_stage_reg_t;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  // Scoreboard of pc values the stage should currently hold, head first.
  logic [XLEN-1:0] sb[$];

  me1_stage_reg_t_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

`ifdef ME1_BRANCH_RESOLVE_EN
  logic            br_taken;
  logic [XLEN-1:0] br_target;
`endif

  me1_stage_reg_t #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
`ifdef ME1_BRANCH_RESOLVE_EN
    ,
    .br_taken  (br_taken),
    .br_target (br_target)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Drive a full beat whose payload fields are derived from pc.
  task automatic offer(input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] p;
    p = pc;
    bus.ACT              = 1'b1;
    bus.r_me1_valid_D    = 1'b1;
    bus.r_me1_pc_D       = p;
    bus.r_me1_alu_D      = ~p;
    bus.r_me1_bradd_D    = p + 32'h1000;
    bus.r_me1_wtdat_D    = p * 3;
    bus.r_me1_rd_D       = p[6:2];
    bus.r_me1_regwrite_D = p[2];
    bus.r_me1_rfwt_sel_D = p[3:2];
    bus.r_me1_memop_D    = p[5:2];
    bus.r_me1_branchop_D = p[4:2];
    bus.r_me1_zero_D     = p[3];
    bus.r_me1_order_D    = p[2];
  endtask

  task automatic idle();
    bus.ACT           = 1'b0;
    bus.r_me1_valid_D = 1'b0;
  endtask

  // One clock: the model decides accept/pop from the inputs and its own
  // occupancy, then updates at the edge. Returns at the following negedge.
  task automatic advance();
    bit              acc, pp;
    logic [XLEN-1:0] pc;
    acc = bus.ACT && bus.r_me1_valid_D && (sb.size() < 2) && !bus.flush;
    pp  = (sb.size() > 0) && bus.me_ready;
    pc  = bus.r_me1_pc_D;
    @(posedge CLK);
    if (RST || bus.flush) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(pc);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; idle(); bus.me_ready = 1'b0; bus.flush = 1'b0;
    advance(); advance();
    RST = 1'b0;
    checks++; if (bus.r_me1_valid_Q !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.r_me1_valid_Q); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.r_me1_pc_Q !== '0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.r_me1_pc_Q); end
    checks++; if (bus.r_me1_alu_Q !== '0) begin errors++; $display("FAIL reset_alu got %h want 0", bus.r_me1_alu_Q); end
  endtask

  task automatic test_basic();
    logic [XLEN-1:0] e;
    offer(32'h100); bus.me_ready = 1'b1;
    advance(); idle();
    checks++; if (bus.r_me1_valid_Q !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.r_me1_valid_Q); end
    e = (sb.size() != 0) ? sb[0] : 32'hDEAD_BEEF;
    checks++; if (bus.r_me1_pc_Q !== 32'h100 || e !== 32'h100) begin errors++; $display("FAIL basic_pc got %h want %h", bus.r_me1_pc_Q, e); end
    checks++; if (bus.r_me1_alu_Q !== ~e) begin errors++; $display("FAIL basic_alu got %h want %h", bus.r_me1_alu_Q, ~e); end
    checks++; if (bus.r_me1_rd_Q !== e[6:2]) begin errors++; $display("FAIL basic_rd got %h want %h", bus.r_me1_rd_Q, e[6:2]); end
    advance();
    checks++; if (bus.r_me1_valid_Q !== 1'b0) begin errors++; $display("FAIL basic_drained_valid got %b want 0", bus.r_me1_valid_Q); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] got[$];
    bit              took;
    bus.me_ready = 1'b0;
    offer(32'h10); advance();
    offer(32'h14); advance();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_in_ready got %b want 0", bus.in_ready); end
    offer(32'h18); advance(); advance();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.r_me1_pc_Q !== 32'h10) begin errors++; $display("FAIL stall_head got %h want 00000010", bus.r_me1_pc_Q); end
    bus.me_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.r_me1_valid_Q === 1'b1) begin
        checks++;
        if (sb.size() == 0 || bus.r_me1_pc_Q !== sb[0]) begin
          errors++; $display("FAIL stall_drain_head got %h want %h", bus.r_me1_pc_Q, (sb.size() != 0) ? sb[0] : 32'hX);
        end
        got.push_back(bus.r_me1_pc_Q);
      end
      took = bus.ACT && bus.in_ready;
      advance();
      if (took) idle();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL stall_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'h10 + 4*i) begin errors++; $display("FAIL stall_order[%0d] got %h want %h", i, got[i], 32'h10 + 4*i); end
    end
  endtask

  task automatic test_back_to_back();
    int npops = 0;
    bus.me_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.r_me1_valid_Q === 1'b1) npops++;
      offer(32'h200 + 4*i);
      advance();
      checks++;
      if (bus.r_me1_valid_Q !== 1'b1 || bus.in_ready !== 1'b1 || bus.r_me1_pc_Q !== 32'h200 + 4*i || sb.size() == 0 || sb[0] !== bus.r_me1_pc_Q) begin
        errors++; $display("FAIL b2b[%0d] got v=%b rdy=%b pc=%h want v=1 rdy=1 pc=%h", i, bus.r_me1_valid_Q, bus.in_ready, bus.r_me1_pc_Q, 32'h200 + 4*i);
      end
    end
    idle();
    if (bus.r_me1_valid_Q === 1'b1) npops++;
    advance();
    checks++; if (npops != 8) begin errors++; $display("FAIL b2b_pops got %0d want 8", npops); end
    checks++; if (bus.r_me1_valid_Q !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", bus.r_me1_valid_Q); end
  endtask

  task automatic test_flush();
    bus.me_ready = 1'b0;
    offer(32'h20); advance();
    offer(32'h24); advance();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_in_ready got %b want 0", bus.in_ready); end
    offer(32'h300); bus.flush = 1'b1;
    advance();
    bus.flush = 1'b0; idle();
    checks++; if (bus.r_me1_valid_Q !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.r_me1_valid_Q); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.r_me1_pc_Q !== 32'h20) begin errors++; $display("FAIL flush_retain_pc got %h want 00000020", bus.r_me1_pc_Q); end
    bus.me_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      advance();
      checks++;
      if (bus.r_me1_valid_Q !== 1'b0 || bus.r_me1_pc_Q === 32'h300) begin
        errors++; $display("FAIL flush_after[%0d] got v=%b pc=%h want v=0", c, bus.r_me1_valid_Q, bus.r_me1_pc_Q);
      end
    end
    offer(32'h40); advance(); idle();
    checks++;
    if (bus.r_me1_valid_Q !== 1'b1 || sb.size() == 0 || bus.r_me1_pc_Q !== sb[0]) begin
      errors++; $display("FAIL flush_resume got v=%b pc=%h want v=1 pc=00000040", bus.r_me1_valid_Q, bus.r_me1_pc_Q);
    end
    advance();
  endtask

  task automatic test_bubble();
    bus.me_ready = 1'b1;
    bus.ACT = 1'b1; bus.r_me1_valid_D = 1'b0; bus.r_me1_pc_D = 32'h500;
    for (int c = 0; c < 2; c++) begin
      advance();
      checks++;
      if (bus.r_me1_valid_Q !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL bubble[%0d] got v=%b rdy=%b want v=0 rdy=1", c, bus.r_me1_valid_Q, bus.in_ready);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.me_ready = 1'b0;
    offer(32'h30); advance();
    offer(32'h34); advance();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pre_in_ready got %b want 0", bus.in_ready); end
    offer(32'h38); bus.flush = 1'b1; RST = 1'b1;
    advance();
    RST = 1'b0; bus.flush = 1'b0; idle();
    checks++; if (bus.r_me1_valid_Q !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.r_me1_valid_Q); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if (bus.r_me1_pc_Q !== '0 || bus.r_me1_alu_Q !== '0 || bus.r_me1_bradd_Q !== '0 || bus.r_me1_wtdat_Q !== '0) begin
      errors++; $display("FAIL rstmid_words got pc=%h alu=%h bradd=%h wtdat=%h want all 0", bus.r_me1_pc_Q, bus.r_me1_alu_Q, bus.r_me1_bradd_Q, bus.r_me1_wtdat_Q);
    end
    checks++;
    if ({bus.r_me1_rd_Q, bus.r_me1_regwrite_Q, bus.r_me1_rfwt_sel_Q, bus.r_me1_memop_Q, bus.r_me1_branchop_Q, bus.r_me1_zero_Q, bus.r_me1_order_Q} !== '0) begin
      errors++; $display("FAIL rstmid_fields got rd=%h memop=%h branchop=%h want all 0", bus.r_me1_rd_Q, bus.r_me1_memop_Q, bus.r_me1_branchop_Q);
    end
    bus.me_ready = 1'b1;
    advance();
    checks++; if (bus.r_me1_valid_Q !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b want 0", bus.r_me1_valid_Q); end
  endtask

`ifdef ME1_BRANCH_RESOLVE_EN
  task automatic test_branch();
    bus.me_ready = 1'b0;
    offer(32'h50); bus.r_me1_branchop_D = 3'b010; bus.r_me1_zero_D = 1'b0; bus.r_me1_bradd_D = 32'h4000;
    advance(); idle();
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_bne_taken got %b want 1", br_taken); end
    checks++; if (br_target !== 32'h4000) begin errors++; $display("FAIL br_target got %h want 00004000", br_target); end
    bus.me_ready = 1'b1;
    offer(32'h54); bus.r_me1_branchop_D = 3'b010; bus.r_me1_zero_D = 1'b1; bus.r_me1_bradd_D = 32'h4000;
    advance(); idle();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_bne_not_taken got %b want 0", br_taken); end
    offer(32'h58); bus.r_me1_branchop_D = 3'b011; bus.r_me1_zero_D = 1'b0; bus.r_me1_bradd_D = 32'h4444;
    advance(); idle();
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h4444) begin errors++; $display("FAIL br_jump got %b/%h want 1/00004444", br_taken, br_target); end
    advance();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_gated got %b want 0", br_taken); end
  endtask
`endif

  initial begin
    RST = 1'b1;
    idle();
    bus.me_ready = 1'b0;
    bus.flush    = 1'b0;
    offer(32'h0);
    idle();
    @(negedge CLK);
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_flush();
    test_bubble();
    test_reset_mid();
`ifdef ME1_BRANCH_RESOLVE_EN
    test_branch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/me1_stage_reg_t.md
Name: me1_stage_reg_t

Overview:
- Receiving end of the EX1->ME1 stage transfer. Captures the bundle the EX1 output stage drives onto the r_me1_*_D / ACT write strobes.
- Holds the bundle in a 2-entry in-order skid buffer and presents it as registered r_me1_*_Q values to the ME1 stage.
- Adds back-pressure toward EX1 (in_ready), downstream stall acceptance (me_ready) and pipeline flush.
- Sits between the EX1 output logic and the ME1 memory/writeback-select logic.

Parameters:
XLEN, 32, width of pc/alu/bradd/wtdat fields
RD_W, 5, destination register index width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active high
ACT  in  1  EX1 write strobe; a beat is offered when ACT=1
r_me1_valid_D  in  1  beat carries a real instruction
r_me1_pc_D / r_me1_alu_D / r_me1_bradd_D / r_me1_wtdat_D  in  XLEN each  payload
r_me1_rd_D  in  RD_W  destination register
r_me1_regwrite_D  in  1  register write flag
r_me1_rfwt_sel_D  in  2  writeback source select
r_me1_memop_D  in  4  memory op code
r_me1_branchop_D  in  3  branch op code
r_me1_zero_D  in  1  ALU compare flag
r_me1_order_D  in  1  issue-order tag
in_ready  out  1  buffer can accept a beat (registered)
me_ready  in  1  ME1 consumes the head entry this cycle
flush  in  1  discard all held and incoming beats
r_me1_valid_Q  out  1  head entry present
r_me1_*_Q  out  same widths as *_D  head entry payload, registered

Behaviour:
- Accept = ACT & r_me1_valid_D & in_ready & ~flush. Bubbles (valid_D=0) are never stored.
- If ACT=1 and in_ready=0, the beat is not captured. EX1 must hold the beat until in_ready=1; the block does not check this.
- Pop = r_me1_valid_Q & me_ready.
- Storage: MAIN (drives the Q outputs) and SKID. Occupancy 0..2. Order is strictly FIFO.
- State EMPTY:
  - accept -> MAIN=beat, go to ONE.
- State ONE:
  - accept & pop -> MAIN=beat, stay in ONE.
  - accept & ~pop -> SKID=beat, go to FULL.
  - ~accept & pop -> go to EMPTY.
- State FULL:
  - pop -> MAIN=SKID, go to ONE.
  - No accept is possible in FULL.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. Updated on the clock edge of the state change.
- Latency: a beat accepted on edge N is visible on Q from edge N (1-cycle register latency). Throughput is 1 beat/cycle while me_ready=1.
- r_me1_valid_Q = 1 in ONE/FULL. Q payload holds its value while not popped.
- On EMPTY, Q payload retains the last value; only valid_Q is meaningful.
- flush (synchronous):
  - Next state is EMPTY, in_ready=1.
  - An accept in the same cycle is dropped; a pop in the same cycle is ignored.
  - Payload registers are not cleared.
- Reset: RST=1 at a clock edge forces EMPTY, in_ready=1, r_me1_valid_Q=0 and every r_me1_*_Q=0. Reset has priority over flush and accept.
- Reset asserted mid-transfer discards both entries.

Optional Feature:
- Macro ME1_BRANCH_RESOLVE_EN.
- When defined, adds outputs br_taken (1) and br_target (XLEN), combinational from MAIN, gated by r_me1_valid_Q.
- br_taken by branchop:
  - 000: 0
  - 001: zero
  - 010: ~zero
  - 011: 1
  - 1xx: zero
- br_target = r_me1_bradd_Q.
- When undefined, these ports and their logic do not exist; all other behaviour is unchanged.

Test Plan:
- Reset, then ACT=1, valid_D=1, pc_D=0x100, me_ready=1 for one cycle -> next cycle valid_Q=1, pc_Q=0x100; the cycle after, valid_Q=0, in_ready=1.
- me_ready=0; push pc 0x10 then 0x14 -> in_ready=0 after second edge. Third beat 0x18 held with ACT=1 -> not captured. Raise me_ready -> Q sequence 0x10, 0x14, 0x18, no loss or duplication.
- Continuous beats 0x200..0x21C with me_ready=1 -> 8 pops on 8 consecutive cycles, in_ready stays 1.
- State FULL, assert flush while ACT=1 (pc 0x300) -> next cycle valid_Q=0, in_ready=1; 0x300 never appears.
- ACT=1 with valid_D=0 -> valid_Q stays 0; also RST mid-FULL -> all Q=0, in_ready=1.
- With ME1_BRANCH_RESOLVE_EN: branchop=010, zero=0, bradd=0x4000 -> br_taken=1, br_target=0x4000; zero=1 -> br_taken=0.
